// File: rtl/dht11_responder.sv
// DHT11 sensor emulator on a single open-drain wire: detects the host start pulse,
// answers with the response preamble and a 40-bit frame (4 data bytes + checksum).
module dht11_responder #(
  parameter int unsigned CLKS_PER_US  = 100,
  parameter int unsigned START_MIN_US = 18000,
  parameter int unsigned RESP_DLY_US  = 30,
  parameter int unsigned RESP_US      = 80,
  parameter int unsigned BIT_LOW_US   = 50,
  parameter int unsigned BIT0_HI_US   = 28,
  parameter int unsigned BIT1_HI_US   = 70
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] tmp_int,
  input  logic [7:0] tmp_dec,
  input  logic       bad_crc,
  inout  wire        dht_data,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned StartCyc  = START_MIN_US * CLKS_PER_US;
  localparam int unsigned RelCyc    = RESP_DLY_US * CLKS_PER_US;
  localparam int unsigned RespCyc   = RESP_US * CLKS_PER_US;
  localparam int unsigned BitLowCyc = BIT_LOW_US * CLKS_PER_US;
  localparam int unsigned Bit0Cyc   = BIT0_HI_US * CLKS_PER_US;
  localparam int unsigned Bit1Cyc   = BIT1_HI_US * CLKS_PER_US;
  localparam int unsigned MaxCyc    = max_u(max_u(max_u(StartCyc, RelCyc),
                                                  max_u(RespCyc, BitLowCyc)),
                                            max_u(Bit0Cyc, Bit1Cyc));
  localparam int unsigned CntW      = $clog2(MaxCyc + 1);

  typedef logic [CntW-1:0] cnt_t;

  // Terminal counts: an interval of N cycles ends when the counter reads N-1.
  localparam cnt_t          RelLast    = cnt_t'(RelCyc - 1);
  localparam cnt_t          RespLast   = cnt_t'(RespCyc - 1);
  localparam cnt_t          BitLowLast = cnt_t'(BitLowCyc - 1);
  localparam cnt_t          Bit0Last   = cnt_t'(Bit0Cyc - 1);
  localparam cnt_t          Bit1Last   = cnt_t'(Bit1Cyc - 1);
  localparam logic [CntW:0] StartLen   = (CntW + 1)'(StartCyc);

  typedef enum logic [2:0] {
    StIdle,
    StHostLow,
    StHostRel,
    StRespLo,
    StRespHi,
    StBitLo,
    StBitHi,
    StEndLo
  } state_e;

  state_e      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [39:0] shreg_q, shreg_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        armed_q, armed_d;
  logic        done_d;
  logic        frame_done_q;
  logic [7:0]  frame_cnt_q;
  logic        sync1_q, line_s;
  logic        drive_low;
  logic [7:0]  csum_raw, csum;
  logic [CntW:0] low_len;

  // Synchronizer idles high so reset looks like a released bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      line_s  <= 1'b1;
    end else begin
      sync1_q <= dht_data;
      line_s  <= sync1_q;
    end
  end

  assign csum_raw = hum_int + hum_dec + tmp_int + tmp_dec;
  assign csum     = bad_crc ? ~csum_raw : csum_raw;
  // The IDLE cycle that saw the first low also counts toward the pulse length.
  assign low_len  = {1'b0, cnt_q} + {{CntW{1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    armed_d   = armed_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (line_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = StHostLow;
        end
      end
      StHostLow: begin
        if (line_s) begin
          if (low_len >= StartLen) begin
            shreg_d   = {hum_int, hum_dec, tmp_int, tmp_dec, csum};
            bit_cnt_d = '0;
            state_d   = StHostRel;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StHostRel: if (cnt_q == RelLast) state_d = StRespLo;
      StRespLo:  if (cnt_q == RespLast) state_d = StRespHi;
      StRespHi:  if (cnt_q == RespLast) state_d = StBitLo;
      StBitLo:   if (cnt_q == BitLowLast) state_d = StBitHi;
      StBitHi: begin
        if (cnt_q == (shreg_q[39] ? Bit1Last : Bit0Last)) begin
          shreg_d = {shreg_q[38:0], 1'b0};
          if (bit_cnt_q == 6'd39) begin
            state_d = StEndLo;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            state_d   = StBitLo;
          end
        end
      end
      StEndLo: begin
        if (cnt_q == BitLowLast) begin
          state_d = StIdle;
          armed_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      armed_q      <= 1'b1;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      armed_q      <= armed_d;
      frame_done_q <= done_d;
      if (done_d) frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  // Decoded straight from the state flops so reset releases the bus at once.
  assign drive_low  = (state_q == StRespLo) || (state_q == StBitLo) || (state_q == StEndLo);
  assign busy       = (state_q != StIdle) && (state_q != StHostLow);
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign dht_data   = drive_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: host pulses, randomized frames and glitches, compared
// cycle by cycle against a waveform built from the byte values.
module tb_dht11_responder;

  // Timing scaled down so hundreds of frames stay short.
  localparam int unsigned C        = 1;
  localparam int unsigned StartUs  = 20;
  localparam int unsigned RelUs    = 3;
  localparam int unsigned RespUs   = 5;
  localparam int unsigned BitLowUs = 2;
  localparam int unsigned Bit0Us   = 1;
  localparam int unsigned Bit1Us   = 4;
  localparam int unsigned StartCyc = StartUs * C;
  localparam int          SyncLat  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] hum_int = '0, hum_dec = '0, tmp_int = '0, tmp_dec = '0;
  logic       bad_crc = 1'b0;
  logic       host_low = 1'b0;
  wire        dht_data;
  logic       busy, frame_done;
  logic [7:0] frame_cnt;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  bit exp_low[$];

  assign dht_data = host_low ? 1'b0 : 1'bz;
  pullup (dht_data);

  always #5 clk = ~clk;

  dht11_responder #(
    .CLKS_PER_US (C),
    .START_MIN_US(StartUs),
    .RESP_DLY_US (RelUs),
    .RESP_US     (RespUs),
    .BIT_LOW_US  (BitLowUs),
    .BIT0_HI_US  (Bit0Us),
    .BIT1_HI_US  (Bit1Us)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hum_int   (hum_int),
    .hum_dec   (hum_dec),
    .tmp_int   (tmp_int),
    .tmp_dec   (tmp_dec),
    .bad_crc   (bad_crc),
    .dht_data  (dht_data),
    .busy      (busy),
    .frame_done(frame_done),
    .frame_cnt (frame_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] make_word(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] d,
                                            input logic bc);
    int         s;
    logic [7:0] cs;
    s  = int'(a) + int'(b) + int'(c) + int'(d);
    cs = 8'(s % 256);
    if (bc) cs = ~cs;
    return {a, b, c, d, cs};
  endfunction

  // 1 = responder pulls the line low, one entry per cycle from host release.
  function automatic void build_expect(input logic [39:0] w);
    exp_low.delete();
    repeat (SyncLat + RelUs * C) exp_low.push_back(1'b0);
    repeat (RespUs * C) exp_low.push_back(1'b1);
    repeat (RespUs * C) exp_low.push_back(1'b0);
    for (int b = 39; b >= 0; b--) begin
      repeat (BitLowUs * C) exp_low.push_back(1'b1);
      repeat ((w[b] ? Bit1Us : Bit0Us) * C) exp_low.push_back(1'b0);
    end
    repeat (BitLowUs * C) exp_low.push_back(1'b1);
  endfunction

  task automatic host_pulse(input int n);
    @(posedge clk);
    #1 host_low = 1'b1;
    repeat (n) @(posedge clk);
    #1 host_low = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] hi, input logic [7:0] hd, input logic [7:0] ti,
                           input logic [7:0] td, input logic bc, input bit glitch,
                           input bit hold_end, input string tag);
    int   len;
    int   bad_line = 0, bad_busy = 0, bad_done = 0;
    bit   hold = 1'b0;
    logic exp_line;
    build_expect(make_word(hi, hd, ti, td, bc));
    len = exp_low.size();
    hum_int = hi; hum_dec = hd; tmp_int = ti; tmp_dec = td; bad_crc = bc;
    repeat (3) @(negedge clk);
    host_pulse(StartCyc);
    for (int i = 0; i < len + 3; i++) begin
      @(negedge clk);
      exp_line = !(((i < len) ? exp_low[i] : 1'b0) || host_low);
      if (dht_data !== exp_line) bad_line++;
      if (busy !== ((i >= SyncLat) && (i < len))) bad_busy++;
      if (frame_done !== (i == len)) bad_done++;
      if (i == SyncLat + 1) begin
        hum_int = 8'($urandom); hum_dec = 8'($urandom);
        tmp_int = 8'($urandom); tmp_dec = 8'($urandom); bad_crc = 1'($urandom);
      end
      if (hold_end && i == len - 2) hold = 1'b1;
      host_low = hold || (glitch && i > SyncLat && i < len - 6 && $urandom_range(0, 5) == 0);
    end
    exp_cnt = (exp_cnt + 1) % 256;
    check({tag, "_line"}, bad_line, 0);
    check({tag, "_busy"}, bad_busy, 0);
    check({tag, "_done"}, bad_done, 0);
    check({tag, "_cnt"}, frame_cnt, exp_cnt);
  endtask

  task automatic quiet_watch(input string tag);
    int bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dht_data !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check({tag, "_quiet"}, bad, 0);
    check({tag, "_cnt"}, frame_cnt, exp_cnt);
  endtask

  task automatic short_pulse(input int n, input string tag);
    repeat (3) @(negedge clk);
    host_pulse(n);
    quiet_watch(tag);
  endtask

  initial begin
    logic [39:0] w;
    int          tgt;
    int          bad;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_line", dht_data, 1);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_frame(8'h35, 8'h00, 8'h18, 8'h00, 1'b0, 1'b0, 1'b0, "basic");
    short_pulse(StartCyc / 2, "short_half");
    short_pulse(StartCyc - 1, "short_edge");
    run_frame(8'h35, 8'h00, 8'h18, 8'h00, 1'b1, 1'b0, 1'b0, "badcrc");
    run_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, "allff");

    // Host still low when the frame ends: must not count as a new start.
    run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1, "hold");
    repeat (StartCyc + 5) @(negedge clk);
    host_low = 1'b0;
    quiet_watch("hold_rearm");

    // Reset asserted while bit 20 is being driven low.
    w = make_word(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    build_expect(w);
    {hum_int, hum_dec, tmp_int, tmp_dec} = w[39:8];
    bad_crc = 1'b0;
    tgt = SyncLat + RelUs * C + 2 * RespUs * C;
    for (int b = 0; b < 19; b++) tgt += BitLowUs * C + (w[39 - b] ? Bit1Us : Bit0Us) * C;
    repeat (3) @(negedge clk);
    host_pulse(StartCyc);
    bad = 0;
    for (int i = 0; i <= tgt; i++) begin
      @(negedge clk);
      if (dht_data !== !exp_low[i]) bad++;
    end
    check("mid_pre_line", bad, 0);
    check("mid_pre_drive", dht_data, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_line", dht_data, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", frame_done, 0);
    check("mid_rst_cnt", frame_cnt, 0);
    exp_cnt = 0;
    // Host goes low during reset; only the low time after release may count.
    host_low = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check("mid_rst_hold", bad, 0);
    rst_n = 1'b1;
    repeat (StartCyc - 3) @(negedge clk);
    host_low = 1'b0;
    quiet_watch("post_rst_short");
    run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0,
              "post_rst");

    for (int f = 0; f < 255; f++) begin
      run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b1,
                1'b0, "b2b");
    end
    check("wrap_cnt", frame_cnt, 0);
    run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0,
              "after_wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dht11_responder.md
DHT11_RESPONDER -- requirements
Module: dht11_responder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  CLKS_PER_US  100    clk cycles per microsecond
  START_MIN_US 18000  minimum host low pulse accepted as start
  RESP_DLY_US  30     delay from host release to response
  RESP_US      80     response low time, then response high time
  BIT_LOW_US   50     low preamble of each bit and of the end marker
  BIT0_HI_US   28     high time for a 0 bit
  BIT1_HI_US   70     high time for a 1 bit
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk        in     1  clock
  rst_n      in     1  reset, asynchronous, active-low
  hum_int    in     8  humidity integer byte
  hum_dec    in     8  humidity decimal byte
  tmp_int    in     8  temperature integer byte
  tmp_dec    in     8  temperature decimal byte
  bad_crc    in     1  1 = transmit inverted checksum (fault injection)
  dht_data   inout  1  single-wire bus, open-drain
  busy       out    1  frame in progress
  frame_done out    1  one-cycle pulse at frame end
  frame_cnt  out    8  completed frames, wraps 255->0

Function
REQ-003 dht_data SHALL be driven only to 0 or high-Z, never to 1; high-Z whenever drive_low is 0.
REQ-004 dht_data SHALL be sampled through a 2-flop synchronizer; all decisions use the synchronized value (line_s).
REQ-005 Every interval of X us SHALL last exactly X*CLKS_PER_US cycles, timed by a cycle counter cleared on each state entry.
REQ-006 States: IDLE, HOST_LOW, HOST_REL, RESP_LO, RESP_HI, BIT_LO, BIT_HI, END_LO.
REQ-007 IDLE: line_s==0 -> HOST_LOW; counter starts at 0.
REQ-008 HOST_LOW: counter saturates at its maximum; on line_s==1, go to HOST_REL if count >= START_MIN_US*CLKS_PER_US, else return to IDLE with no output change.
REQ-009 On HOST_LOW->HOST_REL, a 40-bit shift register SHALL load {hum_int, hum_dec, tmp_int, tmp_dec, csum}.
REQ-010 csum = (hum_int+hum_dec+tmp_int+tmp_dec) mod 256, bitwise-inverted when bad_crc=1; inputs are sampled only at this load.
REQ-011 HOST_REL lasts RESP_DLY_US, line released; then RESP_LO (drive 0, RESP_US), then RESP_HI (release, RESP_US).
REQ-012 Bits SHALL be sent MSB first, 40 bits: BIT_LO drives 0 for BIT_LOW_US; BIT_HI releases for BIT0_HI_US or BIT1_HI_US per the current bit.
REQ-013 After bit 40, END_LO SHALL drive 0 for BIT_LOW_US, then release and enter IDLE.
REQ-014 busy SHALL be 1 from HOST_REL entry until IDLE re-entry.
REQ-015 On END_LO->IDLE: frame_done SHALL pulse for 1 cycle and frame_cnt SHALL increment, modulo 256.
REQ-016 Low levels on line_s while busy SHALL be ignored; a new start is detected only from IDLE.
REQ-017 After a frame, IDLE SHALL require line_s==1 before a low is treated as a new start: line low on IDLE entry waits for high first.
REQ-018 Total frame length after host release SHALL be RESP_DLY+2*RESP+41*BIT_LOW+sum(bit high times) us exactly.

Reset
REQ-019 rst_n low SHALL asynchronously force state IDLE, drive_low=0 (bus released immediately, including mid-frame), busy=0, frame_done=0, frame_cnt=0, shift register=0, synchronizer flops=1.
REQ-020 After rst_n deassertion, the first start SHALL need a full START_MIN_US low measured after reset.

Verification (CLKS_PER_US=10)
REQ-021 Host low 18 ms, release; inputs 0x35,0x00,0x18,0x00 -> line low 800 cycles at +300, high 800, then bits 00110101 00000000 00011000 00000000 01001101; frame_done once; frame_cnt=1.
REQ-022 Host low 10 ms -> bus never driven, busy stays 0, frame_cnt unchanged.
REQ-023 Same inputs as REQ-021 with bad_crc=1 -> checksum bits 10110010; data bytes unchanged.
REQ-024 Inputs 0xFF,0xFF,0xFF,0xFF -> csum 0xFC (carries wrap); each 1-bit high lasts 700 cycles, each 0-bit high 280 cycles.
REQ-025 rst_n asserted during bit 20 -> dht_data high-Z same cycle; busy=0; no frame_done; a following 18 ms start yields a complete, correct frame.
REQ-026 256 back-to-back valid frames -> frame_cnt wraps to 0; host glitches during a frame do not disturb bit timing.
